axis_to_aximm: RTL and testbench
================================

AXIS_TO_AXIMM -- requirements
Module: axis_to_aximm
Interface
REQ-001 SHALL have parameter DW, default 512: data width in bits; a multiple of 8, at least 64.
REQ-002 SHALL have parameter AW, default 64: AXI address width.
REQ-003 SHALL have parameter BURST_BEATS, default 16: beats per burst; 1..256.
REQ-004 SHALL have parameter BASE_ADDR, default 0, and REGION_BYTES, default 2**20: write window; REGION_BYTES is a multiple of BURST_BEATS*DW/8.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8: limit on unacknowledged bursts; 1..255.
REQ-006 SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- AXIS_IN_TDATA  in  DW  stream data
- AXIS_IN_TKEEP  in  DW/8  byte enables
- AXIS_IN_TLAST  in  1  end of packet
- AXIS_IN_TVALID  in  1  beat valid
- AXIS_IN_TREADY  out  1  beat accepted
- M_AXI_AWADDR  out  AW  burst address
- M_AXI_AWLEN  out  8  constant BURST_BEATS-1
- M_AXI_AWSIZE  out  3  constant log2(DW/8)
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
- M_AXI_AWVALID  out  1  address valid
- M_AXI_AWREADY  in  1  address accepted
- M_AXI_WDATA  out  DW  write data
- M_AXI_WSTRB  out  DW/8  write strobes
- M_AXI_WLAST  out  1  last beat of burst
- M_AXI_WVALID  out  1  data valid
- M_AXI_WREADY  in  1  data accepted
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  response valid
- M_AXI_BREADY  out  1  tied to 1
- err_count  out  16  count of non-OKAY responses
Function
REQ-007 The FSM SHALL have states IDLE, ADDR, DATA and PAD.
REQ-008 IDLE->ADDR SHALL occur the cycle after TVALID=1, provided outstanding<MAX_OUTSTANDING; otherwise the FSM SHALL hold in IDLE.
REQ-009 In ADDR, AWVALID SHALL be 1 and AWADDR SHALL be stable until AWREADY; on that handshake the FSM SHALL go to DATA.
REQ-010 In DATA, WDATA, WSTRB and WVALID SHALL be combinational from TDATA, TKEEP and TVALID, and TREADY SHALL equal WREADY.
REQ-011 A beat counter SHALL increment on each W handshake; WLAST=1 when the counter equals BURST_BEATS-1.
REQ-012 A handshake with WLAST=1 SHALL go to IDLE and reset the beat counter.
REQ-013 A handshake with TLAST=1 before the last beat SHALL go to PAD.
REQ-014 In PAD: TREADY=0, WVALID=1, WSTRB=0, WDATA=0; PAD SHALL emit beats until the WLAST handshake, then go to IDLE.
REQ-015 After each AW handshake, AWADDR SHALL advance by BURST_BEATS*DW/8; when it reaches BASE_ADDR+REGION_BYTES it SHALL wrap to BASE_ADDR.
REQ-016 The outstanding counter SHALL increment on an AW handshake and decrement on a B handshake; if both occur in the same cycle it SHALL be unchanged.
REQ-017 AWVALID, WVALID and TREADY SHALL be 0 in IDLE; WVALID and TREADY SHALL be 0 in ADDR.
Reset
REQ-018 Reset SHALL immediately force IDLE, AWVALID=0, WVALID=0, TREADY=0, AWADDR=BASE_ADDR, and zero the beat, outstanding and error counters, including mid-burst.
REQ-019 BREADY SHALL be 1 during reset and at all times.
Configuration
REQ-020 With AXIS_TO_AXIMM_ERRCNT_EN defined, err_count SHALL increment, saturating at 16'hFFFF, on each B handshake with BRESP!=0.
REQ-021 Without AXIS_TO_AXIMM_ERRCNT_EN, err_count SHALL be constant 0 and no counter logic SHALL be built.
Structure
REQ-022 The FSM state enumeration and the AXI constants (RESP_OKAY, BURST_INCR) SHALL reside in the shared package axi_stream_pkg.
REQ-023 The outstanding counter SHALL be a sub-module, burst_credit_counter; everything else SHALL be flat.
Verification
REQ-024 Stream 32 beats with TLAST on beat 32, BURST_BEATS=16 -> two bursts at addresses 0x0 and 0x400 with WLAST on beats 16 and 32.
REQ-025 Stream 5 beats with TLAST on beat 5 -> one burst: 5 data beats, then 11 PAD beats with WSTRB=0; TREADY=0 during PAD.
REQ-026 REGION_BYTES=0x800, three bursts -> addresses 0x0, 0x400, 0x0.
REQ-027 Hold BVALID=0 and MAX_OUTSTANDING=2 -> exactly 2 AW handshakes occur, then stall in IDLE; one BVALID pulse -> third AW follows.
REQ-028 BRESP=2'b10 on 3 responses with the macro defined -> err_count=3; without the macro -> err_count=0; assert reset mid-DATA -> all outputs return to reset values that cycle.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared types and AXI constants for the stream-to-memory-mapped write bridge.
package axi_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      PAD  = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;

   // AxSIZE encoding for a beat of the given byte count.
   function automatic logic [2:0] axi_size(input int bytes);
      return 3'($clog2(bytes));
   endfunction

endpackage

// File: rtl/axis_to_aximm_if.sv
// Bundles the AXI-Stream input and the AXI4 write-channel master of the bridge.
interface axis_to_aximm_if #(
   parameter int DW = 512,
   parameter int AW = 64
);
   // Every channel transfers on a rising edge where VALID and READY are both 1;
   // a source holds VALID and its payload steady until that edge.
   logic [DW-1:0]   AXIS_IN_TDATA;
   logic [DW/8-1:0] AXIS_IN_TKEEP;
   logic            AXIS_IN_TLAST;
   logic            AXIS_IN_TVALID;
   logic            AXIS_IN_TREADY;

   logic [AW-1:0]   M_AXI_AWADDR;
   logic [7:0]      M_AXI_AWLEN;
   logic [2:0]      M_AXI_AWSIZE;
   logic [1:0]      M_AXI_AWBURST;
   logic            M_AXI_AWVALID;
   logic            M_AXI_AWREADY;

   logic [DW-1:0]   M_AXI_WDATA;
   logic [DW/8-1:0] M_AXI_WSTRB;
   logic            M_AXI_WLAST;
   logic            M_AXI_WVALID;
   logic            M_AXI_WREADY;

   logic [1:0]      M_AXI_BRESP;
   logic            M_AXI_BVALID;
   logic            M_AXI_BREADY;

   modport master (
      input  AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TLAST, AXIS_IN_TVALID,
      output AXIS_IN_TREADY,
      output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY
   );

   modport slave (
      output AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TLAST, AXIS_IN_TVALID,
      input  AXIS_IN_TREADY,
      input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY
   );

endinterface

// File: rtl/burst_credit_counter.sv
// Tracks bursts whose address was accepted but whose write response is pending.
module burst_credit_counter #(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic has_credit
);

   logic [7:0] count;

   // Simultaneous issue and retire cancel; a stray response never underflows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'd0;
      end else if (inc && !dec) begin
         count <= count + 8'd1;
      end else if (dec && !inc && count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign has_credit = (count < 8'(MAX_OUTSTANDING));

endmodule

// File: rtl/axis_to_aximm.sv
// Writes an AXI-Stream into a circular memory window as fixed-length INCR bursts,
// zero-padding short packets. Define AXIS_TO_AXIMM_ERRCNT_EN to count error responses.
module axis_to_aximm
   import axi_stream_pkg::*;
#(
   parameter int          DW              = 512,
   parameter int          AW              = 64,
   parameter int          BURST_BEATS     = 16,
   parameter logic [63:0] BASE_ADDR       = 64'h0,
   parameter logic [63:0] REGION_BYTES    = 64'h10_0000,
   parameter int          MAX_OUTSTANDING = 8
) (
   input  logic              clk,
   input  logic              reset,
   axis_to_aximm_if.master   bus,
   output logic [15:0]       err_count,
   output state_t            dbg_state
);

   localparam logic [AW-1:0] ADDR_BASE = AW'(BASE_ADDR);
   localparam logic [AW-1:0] ADDR_END  = AW'(BASE_ADDR + REGION_BYTES);
   localparam logic [AW-1:0] ADDR_STEP = AW'(BURST_BEATS * (DW / 8));
   localparam logic [7:0]    LAST_BEAT = 8'(BURST_BEATS - 1);

   state_t        state;
   logic          aw_valid;
   logic [AW-1:0] aw_addr;
   logic [AW-1:0] aw_addr_inc;
   logic [7:0]    beat_cnt;
   logic          has_credit;
   logic          aw_hs;
   logic          w_hs;
   logic          w_last;
   logic          b_hs;

   assign aw_hs       = aw_valid & bus.M_AXI_AWREADY;
   assign w_hs        = bus.M_AXI_WVALID & bus.M_AXI_WREADY;
   assign b_hs        = bus.M_AXI_BVALID & bus.M_AXI_BREADY;
   assign w_last      = (beat_cnt == LAST_BEAT);
   assign aw_addr_inc = aw_addr + ADDR_STEP;

   assign bus.M_AXI_AWADDR  = aw_addr;
   assign bus.M_AXI_AWVALID = aw_valid;
   assign bus.M_AXI_AWLEN   = LAST_BEAT;
   assign bus.M_AXI_AWSIZE  = axi_size(DW / 8);
   assign bus.M_AXI_AWBURST = BURST_INCR;
   assign bus.M_AXI_WLAST   = w_last;
   assign bus.M_AXI_BREADY  = 1'b1;
   assign dbg_state         = state;

   // Stream passes straight through in DATA; PAD drives null-strobe beats.
   always_comb begin
      bus.M_AXI_WVALID   = 1'b0;
      bus.M_AXI_WDATA    = '0;
      bus.M_AXI_WSTRB    = '0;
      bus.AXIS_IN_TREADY = 1'b0;
      case (state)
         DATA: begin
            bus.M_AXI_WVALID   = bus.AXIS_IN_TVALID;
            bus.M_AXI_WDATA    = bus.AXIS_IN_TDATA;
            bus.M_AXI_WSTRB    = bus.AXIS_IN_TKEEP;
            bus.AXIS_IN_TREADY = bus.M_AXI_WREADY;
         end
         PAD:     bus.M_AXI_WVALID = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         aw_valid <= 1'b0;
         aw_addr  <= ADDR_BASE;
         beat_cnt <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.AXIS_IN_TVALID && has_credit) begin
                  state    <= ADDR;
                  aw_valid <= 1'b1;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  aw_valid <= 1'b0;
                  state    <= DATA;
                  aw_addr  <= (aw_addr_inc == ADDR_END) ? ADDR_BASE : aw_addr_inc;
               end
            end
            DATA: begin
               if (w_hs) begin
                  if (w_last) begin
                     state    <= IDLE;
                     beat_cnt <= 8'd0;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                     if (bus.AXIS_IN_TLAST) state <= PAD;
                  end
               end
            end
            PAD: begin
               if (w_hs) begin
                  if (w_last) begin
                     state    <= IDLE;
                     beat_cnt <= 8'd0;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   burst_credit_counter #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_credit (
      .clk        (clk),
      .reset      (reset),
      .inc        (aw_hs),
      .dec        (b_hs),
      .has_credit (has_credit)
   );

`ifdef AXIS_TO_AXIMM_ERRCNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= 16'd0;
      end else if (b_hs && bus.M_AXI_BRESP != RESP_OKAY && err_count != 16'hFFFF) begin
         err_count <= err_count + 16'd1;
      end
   end
`else
   logic unused_bresp;
   assign unused_bresp = ^bus.M_AXI_BRESP;
   assign err_count    = 16'h0;
`endif

endmodule

// File: tb/tb_axis_to_aximm.sv
// Directed bench for axis_to_aximm: bursts, padding, address wrap, credit stall,
// error counting and asynchronous reset.
module tb_axis_to_aximm;
   import axi_stream_pkg::*;

   localparam int DW = 512;
   localparam int AW = 32;
   localparam int BB = 16;
   localparam int RW = 1 + 1 + DW / 8 + 32;

`ifdef AXIS_TO_AXIMM_ERRCNT_EN
   localparam logic [15:0] EXP_ERR = 16'd3;
`else
   localparam logic [15:0] EXP_ERR = 16'd0;
`endif

   logic        clk;
   logic        reset;
   logic [15:0] err_count;
   state_t      dbg_state;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] exp_aw_q[$];
   logic [AW-1:0] got_aw[$];
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] got_w[$];

   axis_to_aximm_if #(.DW(DW), .AW(AW)) bus ();

   axis_to_aximm #(
      .DW              (DW),
      .AW              (AW),
      .BURST_BEATS     (BB),
      .BASE_ADDR       (64'h0),
      .REGION_BYTES    (64'h800),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .err_count (err_count),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] mk_rec(input logic last, input logic trdy,
                                            input logic [DW/8-1:0] strb, input logic [31:0] d);
      return {last, trdy, strb, d};
   endfunction

   task automatic exp_burst(input logic [31:0] base, input int n);
      for (int i = 0; i < BB; i++) begin
         if (i < n) exp_q.push_back(mk_rec(i == BB - 1, 1'b1, {(DW/8){1'b1}}, base + 32'(i)));
         else       exp_q.push_back(mk_rec(i == BB - 1, 1'b0, '0, 32'h0));
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) got_aw.push_back(bus.M_AXI_AWADDR);
         if (bus.M_AXI_WVALID && bus.M_AXI_WREADY)
            got_w.push_back(mk_rec(bus.M_AXI_WLAST, bus.AXIS_IN_TREADY,
                                   bus.M_AXI_WSTRB, bus.M_AXI_WDATA[31:0]));
      end
   end

   task automatic compare_logs(input string tag);
      check({tag, "_aw_count"}, got_aw.size(), exp_aw_q.size());
      for (int i = 0; i < exp_aw_q.size(); i++)
         if (i < got_aw.size()) check($sformatf("%s_awaddr%0d", tag, i), got_aw[i], exp_aw_q[i]);
      check({tag, "_w_count"}, got_w.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_w.size()) check($sformatf("%s_wbeat%0d", tag, i), got_w[i], exp_q[i]);
      exp_aw_q.delete();
      got_aw.delete();
      exp_q.delete();
      got_w.delete();
   endtask

   // ---------------- drivers ----------------
   task automatic present(input logic [31:0] d, input logic last);
      bus.AXIS_IN_TDATA  = DW'(d);
      bus.AXIS_IN_TKEEP  = '1;
      bus.AXIS_IN_TLAST  = last;
      bus.AXIS_IN_TVALID = 1'b1;
   endtask

   task automatic push_beat(input logic [31:0] d, input logic last);
      int guard = 0;
      present(d, last);
      @(negedge clk);
      while (!bus.AXIS_IN_TREADY && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("tready_timeout", bus.AXIS_IN_TREADY, 1'b1);
      @(posedge clk); #1;
      bus.AXIS_IN_TVALID = 1'b0;
      bus.AXIS_IN_TLAST  = 1'b0;
   endtask

   task automatic send_packet(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) push_beat(base + 32'(i), i == n - 1);
   endtask

   task automatic wait_idle(input string tag);
      int guard = 0;
      @(negedge clk);
      while (dbg_state != IDLE && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check({tag, "_idle_timeout"}, dbg_state, IDLE);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic b_pulse(input logic [1:0] resp);
      @(posedge clk); #1;
      bus.M_AXI_BVALID = 1'b1;
      bus.M_AXI_BRESP  = resp;
      @(posedge clk); #1;
      bus.M_AXI_BVALID = 1'b0;
      bus.M_AXI_BRESP  = 2'b00;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      reset              = 1'b1;
      bus.AXIS_IN_TDATA  = '0;
      bus.AXIS_IN_TKEEP  = '0;
      bus.AXIS_IN_TLAST  = 1'b0;
      bus.AXIS_IN_TVALID = 1'b0;
      bus.M_AXI_AWREADY  = 1'b0;
      bus.M_AXI_WREADY   = 1'b1;
      bus.M_AXI_BVALID   = 1'b0;
      bus.M_AXI_BRESP    = 2'b00;
      repeat (3) @(posedge clk);
      #1;

      // Reset values and constant outputs
      check("rst_awvalid", bus.M_AXI_AWVALID, 1'b0);
      check("rst_wvalid",  bus.M_AXI_WVALID, 1'b0);
      check("rst_tready",  bus.AXIS_IN_TREADY, 1'b0);
      check("rst_bready",  bus.M_AXI_BREADY, 1'b1);
      check("rst_awaddr",  bus.M_AXI_AWADDR, 32'h0);
      check("rst_errcnt",  err_count, 16'h0);
      check("rst_state",   dbg_state, IDLE);
      check("awlen",       bus.M_AXI_AWLEN, 8'd15);
      check("awsize",      bus.M_AXI_AWSIZE, 3'd6);
      check("awburst",     bus.M_AXI_AWBURST, 2'b01);
      reset = 1'b0;
      @(posedge clk); #1;

      // 32-beat packet: IDLE->ADDR timing, AWADDR held under AWREADY=0, two bursts
      present(32'h1000, 1'b0);
      @(negedge clk);
      check("pre_addr_state",   dbg_state, IDLE);
      check("pre_addr_awvalid", bus.M_AXI_AWVALID, 1'b0);
      @(negedge clk);
      check("addr_state",   dbg_state, ADDR);
      check("addr_awvalid", bus.M_AXI_AWVALID, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("addr_hold_awaddr%0d", i), bus.M_AXI_AWADDR, 32'h0);
         check($sformatf("addr_hold_awvalid%0d", i), bus.M_AXI_AWVALID, 1'b1);
         check($sformatf("addr_hold_tready%0d", i), bus.AXIS_IN_TREADY, 1'b0);
         check($sformatf("addr_hold_wvalid%0d", i), bus.M_AXI_WVALID, 1'b0);
      end
      @(posedge clk); #1;
      bus.M_AXI_AWREADY = 1'b1;
      send_packet(32'h1000, 32);
      wait_idle("pkt32");
      exp_aw_q.push_back(32'h0);
      exp_aw_q.push_back(32'h400);
      exp_burst(32'h1000, 16);
      exp_burst(32'h1010, 16);
      compare_logs("pkt32");

      // Two bursts unacknowledged: the next packet must stall in IDLE
      present(32'h2000, 1'b0);
      repeat (20) @(negedge clk);
      check("stall_aw_count", got_aw.size(), 0);
      check("stall_state",    dbg_state, IDLE);
      check("stall_awvalid",  bus.M_AXI_AWVALID, 1'b0);
      check("stall_tready",   bus.AXIS_IN_TREADY, 1'b0);
      @(posedge clk); #1;
      b_pulse(2'b10);

      // Short packet after the credit returns: wrapped address, 11 pad beats
      send_packet(32'h2000, 5);
      wait_idle("pkt5");
      exp_aw_q.push_back(32'h0);
      exp_burst(32'h2000, 5);
      compare_logs("pkt5");

      b_pulse(2'b10);
      b_pulse(2'b10);
      @(negedge clk);
      check("err_count_3err", err_count, EXP_ERR);
      @(posedge clk); #1;

      // Full burst at 0x400, then an OKAY response leaves the error count alone
      send_packet(32'h3000, 16);
      wait_idle("pkt16");
      exp_aw_q.push_back(32'h400);
      exp_burst(32'h3000, 16);
      compare_logs("pkt16");
      b_pulse(2'b00);
      @(negedge clk);
      check("err_count_okay", err_count, EXP_ERR);
      @(posedge clk); #1;

      // Reset asserted in the middle of a DATA phase
      push_beat(32'h4000, 1'b0);
      push_beat(32'h4001, 1'b0);
      push_beat(32'h4002, 1'b0);
      present(32'h4003, 1'b0);
      @(negedge clk);
      check("mid_state",      dbg_state, DATA);
      check("mid_wvalid",     bus.M_AXI_WVALID, 1'b1);
      check("mid_tready",     bus.AXIS_IN_TREADY, 1'b1);
      check("mid_awaddr",     bus.M_AXI_AWADDR, 32'h400);
      check("mid_aw_count",   got_aw.size(), 1);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_state",   dbg_state, IDLE);
      check("mid_rst_awvalid", bus.M_AXI_AWVALID, 1'b0);
      check("mid_rst_wvalid",  bus.M_AXI_WVALID, 1'b0);
      check("mid_rst_tready",  bus.AXIS_IN_TREADY, 1'b0);
      check("mid_rst_awaddr",  bus.M_AXI_AWADDR, 32'h0);
      check("mid_rst_bready",  bus.M_AXI_BREADY, 1'b1);
      check("mid_rst_errcnt",  err_count, 16'h0);
      bus.AXIS_IN_TVALID = 1'b0;
      exp_aw_q.delete();
      got_aw.delete();
      exp_q.delete();
      got_w.delete();
      guard = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_state", dbg_state, IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
